dsp_shift_mac_neg: RTL

Parametrised, pipelined shift-multiply-accumulate DSP slice for the negative-edge DSP family. Computes P = (A <<< acc_fir) ± A·B, optionally accumulated onto the previous P, with configurable operand and result widths and pipeline depth. It carries a valid pipeline, and optional saturation is compiled in by macro. All registers are clocked on the falling edge of `clk`. The block sits where a single fixed-width shift-add-multiply cell used to sit, feeding FIR and accumulator datapaths.

---
 rtl/dsp_shift_mac_neg.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/dsp_shift_mac_neg.sv
// dsp_shift_mac_neg: pipelined P = (A <<< acc_fir) +/- A*B with optional accumulate, falling-edge clocked.
// Saturating result reduction is compiled in when DSP_SHIFT_MAC_SAT_EN is defined; otherwise P wraps.
module dsp_shift_mac_neg #(
  parameter int A_W         = 20,
  parameter int B_W         = 18,
  parameter int P_W         = 38,
  parameter int SHIFT_W     = 4,
  parameter int PIPE_STAGES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_i,
  input  logic                  subtract_i,
  input  logic                  accumulate_i,
  input  logic signed [A_W-1:0] A,
  input  logic signed [B_W-1:0] B,
  input  logic [SHIFT_W-1:0]    acc_fir,
  output logic signed [P_W-1:0] P,
  output logic                  valid_o,
  output logic                  sat_o
);
  // Internal width holds every term exactly so clamping sees the true sum.
  localparam int SH_MAX = (1 << SHIFT_W) - 1;
  localparam int M1     = (P_W > A_W + B_W) ? P_W : A_W + B_W;
  localparam int M2     = (M1 > A_W + SH_MAX) ? M1 : A_W + SH_MAX;
  localparam int IW     = M2 + 2;
  localparam logic signed [IW-1:0] P_MAX = {{(IW-P_W+1){1'b0}}, {(P_W-1){1'b1}}};
  localparam logic signed [IW-1:0] P_MIN = {{(IW-P_W+1){1'b1}}, {(P_W-1){1'b0}}};

  logic signed [A_W-1:0]  a_s;
  logic signed [B_W-1:0]  b_s;
  logic [SHIFT_W-1:0]     sh_s;
  logic                   sub_s, acc_s, v_s;
  logic signed [IW-1:0]   ax, bx, st_c, pr_c;
  logic signed [IW-1:0]   st_f, pr_f;
  logic                   sub_f, acc_f, v_f;
  logic signed [IW-1:0]   px, sum, nxt;
  logic signed [P_W-1:0]  p_q, p_d;
  logic                   v_q, sat_q, sat_d;

  if (PIPE_STAGES >= 3) begin : g_op
    logic signed [A_W-1:0] a_q;
    logic signed [B_W-1:0] b_q;
    logic [SHIFT_W-1:0]    sh_q;
    logic                  sub0_q, acc0_q, v0_q;
    always_ff @(negedge clk) begin
      if (reset) begin
        a_q    <= '0;
        b_q    <= '0;
        sh_q   <= '0;
        sub0_q <= 1'b0;
        acc0_q <= 1'b0;
        v0_q   <= 1'b0;
      end else begin
        a_q    <= A;
        b_q    <= B;
        sh_q   <= acc_fir;
        sub0_q <= subtract_i;
        acc0_q <= accumulate_i;
        v0_q   <= valid_i;
      end
    end
    assign a_s   = a_q;
    assign b_s   = b_q;
    assign sh_s  = sh_q;
    assign sub_s = sub0_q;
    assign acc_s = acc0_q;
    assign v_s   = v0_q;
  end else begin : g_op_bp
    assign a_s   = A;
    assign b_s   = B;
    assign sh_s  = acc_fir;
    assign sub_s = subtract_i;
    assign acc_s = accumulate_i;
    assign v_s   = valid_i;
  end

  assign ax   = {{(IW-A_W){a_s[A_W-1]}}, a_s};
  assign bx   = {{(IW-B_W){b_s[B_W-1]}}, b_s};
  assign st_c = ax <<< sh_s;
  assign pr_c = ax * bx;

  if (PIPE_STAGES >= 2) begin : g_mul
    logic signed [IW-1:0] st_q, pr_q;
    logic                 sub1_q, acc1_q, v1_q;
    always_ff @(negedge clk) begin
      if (reset) begin
        st_q   <= '0;
        pr_q   <= '0;
        sub1_q <= 1'b0;
        acc1_q <= 1'b0;
        v1_q   <= 1'b0;
      end else begin
        st_q   <= st_c;
        pr_q   <= pr_c;
        sub1_q <= sub_s;
        acc1_q <= acc_s;
        v1_q   <= v_s;
      end
    end
    assign st_f  = st_q;
    assign pr_f  = pr_q;
    assign sub_f = sub1_q;
    assign acc_f = acc1_q;
    assign v_f   = v1_q;
  end else begin : g_mul_bp
    assign st_f  = st_c;
    assign pr_f  = pr_c;
    assign sub_f = sub_s;
    assign acc_f = acc_s;
    assign v_f   = v_s;
  end

  assign px  = {{(IW-P_W){p_q[P_W-1]}}, p_q};
  assign sum = sub_f ? st_f - pr_f : st_f + pr_f;
  assign nxt = acc_f ? px + sum : sum;

`ifdef DSP_SHIFT_MAC_SAT_EN
  logic ovf, unf;
  assign ovf   = nxt > P_MAX;
  assign unf   = nxt < P_MIN;
  assign p_d   = ovf ? P_MAX[P_W-1:0] : unf ? P_MIN[P_W-1:0] : nxt[P_W-1:0];
  assign sat_d = ovf | unf;
`else
  logic unused_hi;
  assign unused_hi = ^{nxt[IW-1:P_W], P_MAX, P_MIN};
  assign p_d       = nxt[P_W-1:0];
  assign sat_d     = 1'b0;
`endif

  always_ff @(negedge clk) begin
    if (reset) begin
      p_q   <= '0;
      v_q   <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      v_q <= v_f;
      if (v_f) begin
        p_q   <= p_d;
        sat_q <= sat_d;
      end
    end
  end

  assign P       = p_q;
  assign valid_o = v_q;
  assign sat_o   = sat_q;
endmodule
